// File: rtl/fb_fill_engine.sv
// Framebuffer fill engine: turns one fill command into a burst of BRAM writes,
// one per arbiter-granted cycle, in constant or incrementing-data mode.
module fb_fill_engine #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_value,
    input  logic              cmd_mode,
    input  logic              abort,
    input  logic              mem_grant,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  words_written
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic                mode_q;
    logic [LEN_W-1:0]    remain_q;
    logic [LEN_W-1:0]    count_q;
    logic [ADDR_W-1:0]   last_addr_q;
    logic [DATA_W-1:0]   last_din_q;
    logic                write_en;

    // Abort beats grant, and reset suppresses the write in the cycle it is asserted.
    assign write_en = (state_q == S_RUN) && mem_grant && !abort && !rst;

    // The port shows the live address/data while writing and the last written pair otherwise.
    assign bram_we       = write_en;
    assign bram_addr     = write_en ? addr_q : last_addr_q;
    assign bram_din      = write_en ? data_q : last_din_q;
    assign cmd_ready     = (state_q == S_IDLE);
    assign busy          = (state_q == S_RUN);
    assign done          = (state_q == S_DONE);
    assign words_written = count_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            mode_q      <= 1'b0;
            remain_q    <= '0;
            count_q     <= '0;
            last_addr_q <= '0;
            last_din_q  <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        count_q <= '0;
                        if (cmd_len != '0) begin
                            state_q  <= S_RUN;
                            addr_q   <= cmd_base;
                            data_q   <= cmd_value;
                            mode_q   <= cmd_mode;
                            remain_q <= cmd_len;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        state_q <= S_DONE;
                    end else if (mem_grant) begin
                        last_addr_q <= addr_q;
                        last_din_q  <= data_q;
                        addr_q      <= addr_q + ADDR_W'(1);
                        if (mode_q) begin
                            data_q <= data_q + DATA_W'(1);
                        end
                        remain_q <= remain_q - LEN_W'(1);
                        count_q  <= count_q + LEN_W'(1);
                        if (remain_q == LEN_W'(1)) begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_fill_engine.sv
// Directed bench for fb_fill_engine: hand-computed write sequences, stalls,
// wrap, zero length, abort, and reset in the middle of a burst.
module tb_fb_fill_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_base;
    logic [15:0] cmd_len;
    logic [15:0] cmd_value;
    logic        cmd_mode;
    logic        abort;
    logic        mem_grant;
    logic        bram_we;
    logic [15:0] bram_addr;
    logic [15:0] bram_din;
    logic        busy;
    logic        done;
    logic [15:0] words_written;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fb_fill_engine #(.ADDR_W(16), .DATA_W(16), .LEN_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_base      (cmd_base),
        .cmd_len       (cmd_len),
        .cmd_value     (cmd_value),
        .cmd_mode      (cmd_mode),
        .abort         (abort),
        .mem_grant     (mem_grant),
        .bram_we       (bram_we),
        .bram_addr     (bram_addr),
        .bram_din      (bram_din),
        .busy          (busy),
        .done          (done),
        .words_written (words_written)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        check({tag, "_we"},    32'(bram_we),   32'd0);
        check({tag, "_addr"},  32'(bram_addr), 32'd0);
        check({tag, "_din"},   32'(bram_din),  32'd0);
        check({tag, "_busy"},  32'(busy),      32'd0);
        check({tag, "_done"},  32'(done),      32'd0);
        check({tag, "_ww"},    32'(words_written), 32'd0);
    endtask

    // Issues one command and walks exp_cycles RUN cycles; stall bit c drops grant
    // on RUN cycle c, abort is raised on RUN cycle abort_at (-1 = never).
    task automatic run_cmd(input string tag, input logic [15:0] base, input logic [15:0] len,
                           input logic [15:0] value, input logic mode, input logic [31:0] stall,
                           input int abort_at, input int exp_cycles, input int exp_writes,
                           input bit hold);
        int n;
        logic [15:0] ea;
        logic [15:0] ed;
        cmd_valid = 1'b1;
        cmd_base  = base;
        cmd_len   = len;
        cmd_value = value;
        cmd_mode  = mode;
        mem_grant = 1'b1;
        abort     = 1'b0;
        #1;
        check({tag, "_accept_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        if (!hold) cmd_valid = 1'b0;
        n = 0;
        for (int c = 0; c < exp_cycles; c++) begin
            mem_grant = !stall[c];
            abort     = (c == abort_at);
            #1;
            check({tag, "_busy"},  32'(busy),      32'd1);
            check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
            if (mem_grant && !abort) begin
                ea = base + 16'(n);
                ed = mode ? value + 16'(n) : value;
                check({tag, "_we"},   32'(bram_we),   32'd1);
                check({tag, "_addr"}, 32'(bram_addr), 32'(ea));
                check({tag, "_din"},  32'(bram_din),  32'(ed));
                n++;
            end else begin
                check({tag, "_we_off"}, 32'(bram_we), 32'd0);
            end
            tick();
        end
        mem_grant = 1'b1;
        abort     = 1'b0;
        #1;
        check({tag, "_done"},      32'(done),          32'd1);
        check({tag, "_done_busy"}, 32'(busy),          32'd0);
        check({tag, "_done_rdy"},  32'(cmd_ready),     32'd0);
        check({tag, "_done_we"},   32'(bram_we),       32'd0);
        check({tag, "_ww"},        32'(words_written), 32'(exp_writes));
        if (exp_writes > 0) begin
            ea = base + 16'(exp_writes - 1);
            check({tag, "_addr_hold"}, 32'(bram_addr), 32'(ea));
        end
        tick();
        check({tag, "_idle_done"},  32'(done),      32'd0);
        check({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_base  = '0;
        cmd_len   = '0;
        cmd_value = '0;
        cmd_mode  = 1'b0;
        abort     = 1'b0;
        mem_grant = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("reset");

        run_cmd("fill4",   16'h0100, 16'd4, 16'hAAAA, 1'b0, 32'h0, -1, 4, 4, 1'b0);
        run_cmd("incr3",   16'h0010, 16'd3, 16'hFFFF, 1'b1, 32'h0, -1, 3, 3, 1'b0);
        run_cmd("stall",   16'h0100, 16'd4, 16'hAAAA, 1'b0, 32'h6, -1, 6, 4, 1'b0);
        run_cmd("wrap",    16'hFFFE, 16'd3, 16'h1234, 1'b0, 32'h0, -1, 3, 3, 1'b0);
        run_cmd("len0",    16'h0200, 16'd0, 16'h5555, 1'b0, 32'h0, -1, 0, 0, 1'b0);

        // Abort on the third write; cmd_valid stays high throughout and must be
        // taken again only once the engine is back in IDLE.
        run_cmd("abort",   16'h0300, 16'd10, 16'h0F0F, 1'b1, 32'h0, 2, 3, 2, 1'b1);
        check("reaccept_busy_pre", 32'(busy), 32'd0);
        tick();
        check("reaccept_busy", 32'(busy), 32'd1);
        cmd_valid = 1'b0;
        abort     = 1'b1;
        #1;
        check("reaccept_abort_we", 32'(bram_we), 32'd0);
        tick();
        abort = 1'b0;
        check("reaccept_done", 32'(done), 32'd1);
        check("reaccept_ww",   32'(words_written), 32'd0);
        tick();

        // Reset two writes into an eight-word burst.
        cmd_valid = 1'b1;
        cmd_base  = 16'h0400;
        cmd_len   = 16'd8;
        cmd_value = 16'h7777;
        cmd_mode  = 1'b0;
        mem_grant = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        check("prerst_addr", 32'(bram_addr), 32'h0402);
        rst = 1'b1;
        #1;
        check("rst_cycle_we", 32'(bram_we), 32'd0);
        tick();
        rst = 1'b0;
        #1;
        check_reset_outputs("midrun_rst");
        tick();
        check("post_rst_done", 32'(done), 32'd0);
        check("post_rst_we",   32'(bram_we), 32'd0);

        run_cmd("after_rst", 16'h0500, 16'd2, 16'h0001, 1'b1, 32'h0, -1, 2, 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fb_fill_engine.md
Name: fb_fill_engine

Overview:
- Write-side engine for the 16-bit block RAM that holds the framebuffer; the VGA scanout is the read side.
- Accepts one fill command per handshake: base address, word count, data value and mode.
- Issues one BRAM write per granted cycle until the count is exhausted, then pulses done.
- Sits between the memory-mapped IO command registers and a BRAM write port, gated by an arbiter grant.

Parameters:
- ADDR_W, 16, BRAM address width; the address wraps modulo 2^ADDR_W.
- DATA_W, 16, BRAM data width.
- LEN_W, 16, width of the word-count field.

Ports:
- clk  input  1  single system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  engine can accept a command (high only in IDLE).
- cmd_base  input  ADDR_W  first write address.
- cmd_len  input  LEN_W  number of words to write.
- cmd_value  input  DATA_W  fill value, or start value in increment mode.
- cmd_mode  input  1  0 = constant fill, 1 = increment (data +1 per word).
- abort  input  1  terminate the current command.
- mem_grant  input  1  arbiter allows a write this cycle.
- bram_we  output  1  write strobe.
- bram_addr  output  ADDR_W  write address.
- bram_din  output  DATA_W  write data.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse on completion or abort.
- words_written  output  LEN_W  count of writes for the last or current command.

Behaviour:
- Reset, synchronous: state=IDLE; cmd_ready=1; bram_we=0, bram_addr=0, bram_din=0; busy=0, done=0; words_written=0.
- rst overrides all inputs, including mid-RUN: no further writes and no done pulse.

States:
- IDLE: cmd_ready=1.
  - cmd_valid & cmd_ready & cmd_len!=0 -> RUN. Latch base, len, value and mode; clear words_written.
  - cmd_valid & cmd_len==0 -> DONE with no write; words_written=0.
- RUN: busy=1, cmd_ready=0; cmd_valid is ignored.
  - Each cycle with mem_grant=1 and abort=0:
    - bram_we=1 combinationally with bram_addr=current address and bram_din=current data.
    - On the clock edge: address += 1 (mod 2^ADDR_W); data += 1 (mod 2^DATA_W) if mode=1, else unchanged; remaining -= 1; words_written += 1.
  - mem_grant=0: bram_we=0 and all counters hold (stall, no lost or duplicate words).
  - Final write: the cycle where remaining==1 and grant=1 -> DONE.
  - abort=1 in RUN: bram_we forced 0 that cycle -> DONE; words_written keeps the count of completed writes.
  - abort and grant in the same cycle: abort wins, so no write occurs.
- DONE: done=1 for exactly one cycle, busy=0, cmd_ready=0 -> IDLE.

Latency and throughput:
- First write can occur in the cycle after acceptance.
- N words with continuous grant: N RUN cycles, then done in cycle N+1 after acceptance.
- Back-to-back: next acceptance is no earlier than the cycle after done. Minimum command period is N+2 cycles.

Other rules:
- Address wrap: base=16'hFFFE, len=3 writes FFFE, FFFF, 0000; no error flag.
- Increment-mode data wraps FFFF -> 0000.
- bram_we is never high outside RUN.
- bram_addr and bram_din hold their last value when not writing.
- The full length (cmd_len=16'hFFFF) is supported; 0 means no operation.

Test Plan:
- Reset, then cmd base=0x0100, len=4, value=0xAAAA, mode=0, grant=1 -> writes 0x0100..0x0103 all 0xAAAA on 4 consecutive cycles; done pulse 1 cycle later; words_written=4.
- Increment mode, base=0x0010, len=3, value=0xFFFF -> data FFFF, 0000, 0001 at 0x0010..0x0012.
- Same fill with grant low on cycles 2 and 3 -> bram_we low on those cycles; exactly 4 writes, no duplicates; done delayed by 2 cycles.
- base=0xFFFE, len=3 -> addresses FFFE, FFFF, 0000; len=0 -> no bram_we, done one cycle after acceptance, words_written=0.
- Abort asserted with grant on the 3rd write of a len=10 command -> 2 writes total, done pulse next cycle, words_written=2; cmd_valid held high during RUN is ignored and accepted only back in IDLE.
- rst asserted mid-RUN -> next cycle all outputs at reset values, no done pulse; a new command after reset executes normally.
